// File: rtl/uc_responde_registra_tiros_pkg.sv
// Shared definitions for the shot-registration responder: FSM state codes
// and the field layout of the shot word written into the shot table.
// Shot word layout (LSB first): posicao, direcao, valid bit on top.
package uc_responde_registra_tiros_pkg;

    typedef enum logic [2:0] {
        INICIAL  = 3'd0,
        CARREGA  = 3'd1,
        BUSCA    = 3'd2,
        ESCREVE  = 3'd3,
        CONFIRMA = 3'd4,
        DESCARTA = 3'd5,
        FIM      = 3'd6
    } estado_t;

    // Position always sits in the low bits of the shot word.
    localparam int POS_LSB = 0;

    // Direction starts right above the position field.
    function automatic int dir_lsb(input int pos_w);
        return POS_LSB + pos_w;
    endfunction

    // Valid bit is the most significant bit of the shot word.
    function automatic int valid_bit(input int pos_w, input int dir_w);
        return POS_LSB + pos_w + dir_w;
    endfunction

endpackage

// File: rtl/uc_responde_registra_tiros_contador.sv
// Saturating up-counter with synchronous clear; clear has priority over
// the increment, and the count holds at all-ones once it gets there.
module contador_saturado #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uc_responde_registra_tiros.sv
// Responder for the inicia/fim shot-registration handshake. On a start
// pulse it latches ship position and direction, scans the shot table's
// valid bits one slot per cycle for a free entry, writes the new shot word
// there and counts it. When all slots are busy the shot is dropped and
// descartado is raised alongside fim.
// Optional feature: define REGISTRA_TIROS_RODIZIO_EN to start each search
// just after the last written slot (round-robin) instead of at slot 0.
module uc_responde_registra_tiros
    import uc_responde_registra_tiros_pkg::*;
#(
    parameter int N_TIROS = 4,
    parameter int IDX_W   = 2,
    parameter int POS_W   = 4,
    parameter int DIR_W   = 2,
    parameter int CNT_W   = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   inicia,
    input  logic [POS_W-1:0]       posicao_nave,
    input  logic [DIR_W-1:0]       direcao,
    input  logic [N_TIROS-1:0]     tiros_validos,
    input  logic                   zera_contagem,
    output logic                   mem_we,
    output logic [IDX_W-1:0]       mem_addr,
    output logic [DIR_W+POS_W:0]   mem_wdata,
    output logic                   fim,
    output logic                   descartado,
    output logic                   ocupado,
    output logic [CNT_W-1:0]       contagem_tiros,
    output logic [2:0]             db_estado
);

    localparam int DIR_LSB   = dir_lsb(POS_W);
    localparam int VALID_BIT = valid_bit(POS_W, DIR_W);
    localparam logic [IDX_W-1:0] ULTIMO_IDX = IDX_W'(N_TIROS - 1);
    localparam logic [IDX_W:0]   ULTIMA_VARREDURA = (IDX_W + 1)'(N_TIROS - 1);

    estado_t          estado_q, estado_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   scan_q, scan_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic             descartado_q, descartado_d;
    logic [IDX_W-1:0] idx_inicio;
    logic             incrementa;

    // Wraps a slot index back to 0 after the last slot.
    function automatic logic [IDX_W-1:0] proximo_idx(input logic [IDX_W-1:0] i);
        return (i == ULTIMO_IDX) ? '0 : i + 1'b1;
    endfunction

`ifdef REGISTRA_TIROS_RODIZIO_EN
    logic [IDX_W-1:0] ultimo_q, ultimo_d;

    // Search begins just after the most recently written slot.
    assign idx_inicio = proximo_idx(ultimo_q);

    // Last-written slot; resets to the final slot so the first search starts at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ultimo_q <= ULTIMO_IDX;
        end else begin
            ultimo_q <= ultimo_d;
        end
    end

    // Remember the slot being written this cycle.
    always_comb begin
        ultimo_d = ultimo_q;
        if (estado_q == ESCREVE) begin
            ultimo_d = idx_q;
        end
    end
`else
    // Lowest free slot always wins.
    assign idx_inicio = '0;
`endif

    // FSM next state, datapath next values and output decode.
    always_comb begin
        estado_d     = estado_q;
        idx_d        = idx_q;
        scan_d       = scan_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        descartado_d = descartado_q;
        mem_we       = 1'b0;
        fim          = 1'b0;
        incrementa   = 1'b0;
        case (estado_q)
            INICIAL: begin
                if (inicia) begin
                    estado_d = CARREGA;
                end
            end
            CARREGA: begin
                pos_d    = posicao_nave;
                dir_d    = direcao;
                idx_d    = idx_inicio;
                scan_d   = '0;
                estado_d = BUSCA;
            end
            BUSCA: begin
                if (!tiros_validos[idx_q]) begin
                    estado_d = ESCREVE;
                end else if (scan_q == ULTIMA_VARREDURA) begin
                    // Every slot checked exactly once: the table is full.
                    descartado_d = 1'b1;
                    estado_d     = DESCARTA;
                end else begin
                    idx_d  = proximo_idx(idx_q);
                    scan_d = scan_q + 1'b1;
                end
            end
            ESCREVE: begin
                mem_we     = 1'b1;
                incrementa = 1'b1;
                estado_d   = CONFIRMA;
            end
            CONFIRMA: begin
                estado_d = FIM;
            end
            DESCARTA: begin
                estado_d = FIM;
            end
            FIM: begin
                fim          = 1'b1;
                descartado_d = 1'b0;
                estado_d     = INICIAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= INICIAL;
            idx_q        <= '0;
            scan_q       <= '0;
            pos_q        <= '0;
            dir_q        <= '0;
            descartado_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            idx_q        <= idx_d;
            scan_q       <= scan_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            descartado_q <= descartado_d;
        end
    end

    // Shot word assembly; address and data are held at 0 outside writes.
    always_comb begin
        mem_wdata = '0;
        mem_addr  = '0;
        if (mem_we) begin
            mem_addr                        = idx_q;
            mem_wdata[POS_LSB +: POS_W]     = pos_q;
            mem_wdata[DIR_LSB +: DIR_W]     = dir_q;
            mem_wdata[VALID_BIT]            = 1'b1;
        end
    end

    contador_saturado #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (zera_contagem),
        .en      (incrementa),
        .count   (contagem_tiros)
    );

    assign descartado = descartado_q;
    assign ocupado    = (estado_q != INICIAL);
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_uc_responde_registra_tiros.sv
// Directed bench for uc_responde_registra_tiros with a small reference model
// of slot selection, latency and the saturating counter (CNT_W=2).
module tb_uc_responde_registra_tiros;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int PW = 4;
    localparam int DW = 2;
    localparam int CW = 2;
    localparam int W  = IW + 1 + DW + PW;

    logic          clock;
    logic          reset_n;
    logic          inicia;
    logic [PW-1:0] posicao_nave;
    logic [DW-1:0] direcao;
    logic [N-1:0]  tiros_validos;
    logic          zera_contagem;
    logic          mem_we;
    logic [IW-1:0] mem_addr;
    logic [DW+PW:0] mem_wdata;
    logic          fim;
    logic          descartado;
    logic          ocupado;
    logic [CW-1:0] contagem_tiros;
    logic [2:0]    db_estado;

    int n_vec;
    int n_err;
    int cnt_exp;
    int last_exp;
    logic [W-1:0] exp_q[$];

    uc_responde_registra_tiros #(
        .N_TIROS (N),
        .IDX_W   (IW),
        .POS_W   (PW),
        .DIR_W   (DW),
        .CNT_W   (CW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .inicia         (inicia),
        .posicao_nave   (posicao_nave),
        .direcao        (direcao),
        .tiros_validos  (tiros_validos),
        .zera_contagem  (zera_contagem),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .fim            (fim),
        .descartado     (descartado),
        .ocupado        (ocupado),
        .contagem_tiros (contagem_tiros),
        .db_estado      (db_estado)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_estado"}, 32'(db_estado), 0);
        check({tag, "_we"}, 32'(mem_we), 0);
        check({tag, "_fim"}, 32'(fim), 0);
        check({tag, "_ocupado"}, 32'(ocupado), 0);
        check({tag, "_descartado"}, 32'(descartado), 0);
    endtask

    // One request: model predicts slot/latency, then the DUT is followed
    // until fim (bounded). poke drives inicia again while busy.
    task automatic run_shot(input logic [N-1:0] val, input logic [PW-1:0] pos,
                            input logic [DW-1:0] dir, input bit zera_wr, input bit poke);
        int start;
        int k;
        int slot;
        bit found;
        bit done;
        int we_seen;
        logic [W-1:0] w;
`ifdef REGISTRA_TIROS_RODIZIO_EN
        start = (last_exp + 1) % N;
`else
        start = 0;
`endif
        found = 0;
        k = 0;
        slot = 0;
        for (int j = 0; j < N; j++) begin
            if (!found && !val[(start + j) % N]) begin
                found = 1;
                k = j;
                slot = (start + j) % N;
            end
        end
        if (found) exp_q.push_back({slot[IW-1:0], 1'b1, dir, pos});

        tiros_validos = val;
        posicao_nave  = pos;
        direcao       = dir;
        @(negedge clock);
        inicia = 1'b1;
        @(posedge clock);
        done = 0;
        we_seen = 0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clock);
            inicia = poke && (c == 2);
            zera_contagem = 1'b0;
            if (mem_we) begin
                we_seen++;
                check("we_cycle", c, 3 + k);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(w[W-1 -: IW]));
                    check("mem_wdata", 32'(mem_wdata), 32'(w[DW+PW:0]));
                end else begin
                    check("we_unexpected", 32'(mem_we), 0);
                end
                if (zera_wr) zera_contagem = 1'b1;
            end
            if (fim) begin
                done = 1;
                check("fim_cycle", c, found ? 5 + k : 3 + N);
                check("descartado", 32'(descartado), 32'(!found));
            end
        end
        inicia = 1'b0;
        if (!done) check("fim_timeout", 32'(done), 1);
        @(negedge clock);
        zera_contagem = 1'b0;
        check_idle("after_fim");
        if (found) begin
            cnt_exp = zera_wr ? 0 : ((cnt_exp < 3) ? cnt_exp + 1 : 3);
            last_exp = slot;
        end
        check("we_count", we_seen, 32'(found));
        check("contagem", 32'(contagem_tiros), cnt_exp);
    endtask

    // Reset asserted while the FSM is scanning a full table.
    task automatic reset_mid_busca();
        bit fim_seen;
        tiros_validos = '1;
        @(negedge clock);
        inicia = 1'b1;
        @(posedge clock);
        @(negedge clock);
        inicia = 1'b0;
        @(negedge clock);
        check("pre_reset_busca", 32'(db_estado), 2);
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_cnt", 32'(contagem_tiros), 0);
        check("async_reset_addr", 32'(mem_addr), 0);
        check("async_reset_wdata", 32'(mem_wdata), 0);
        fim_seen = 0;
        repeat (2) begin
            @(negedge clock);
            fim_seen |= fim;
        end
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clock);
            fim_seen |= fim | mem_we;
        end
        check("no_fim_after_reset", 32'(fim_seen), 0);
        check_idle("post_reset");
        cnt_exp = 0;
        last_exp = N - 1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cnt_exp = 0;
        last_exp = N - 1;
        reset_n = 1'b0;
        inicia = 1'b0;
        posicao_nave = '0;
        direcao = '0;
        tiros_validos = '0;
        zera_contagem = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset");
        check("reset_cnt", 32'(contagem_tiros), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_idle("reset_release");

        // Empty, partial and full tables.
        run_shot(4'b0000, 4'hA, 2'b01, 0, 0);
        run_shot(4'b0111, 4'h3, 2'b10, 0, 0);
        run_shot(4'b1111, 4'h5, 2'b11, 0, 0);
        run_shot(4'b1011, 4'h7, 2'b00, 0, 1);

        reset_mid_busca();

        // Back-to-back writes: round-robin order and counter saturation.
        run_shot(4'b0000, 4'h1, 2'b01, 0, 0);
        run_shot(4'b0000, 4'h2, 2'b10, 0, 0);
        run_shot(4'b0000, 4'h4, 2'b11, 0, 0);
        run_shot(4'b0000, 4'h8, 2'b00, 0, 0);
        run_shot(4'b1101, 4'hF, 2'b01, 0, 1);

        // Clear coinciding with the write wins.
        run_shot(4'b0000, 4'hC, 2'b10, 1, 0);
        run_shot(4'b1110, 4'h6, 2'b01, 0, 0);

        // Standalone clear.
        @(negedge clock);
        zera_contagem = 1'b1;
        @(negedge clock);
        zera_contagem = 1'b0;
        cnt_exp = 0;
        check("zera_idle", 32'(contagem_tiros), cnt_exp);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
